ddr_phase_ctrl: RTL and testbench

Command-driven phase-shift and lock sequencer for a variable-phase DCM in the DDR clocking path. It owns the DCM's reset, PSEN, PSINCDEC and PSDONE handshake and its feedback-tap select, and tracks the absolute phase offset with clamping. It re-locks automatically after lock loss and restores the last programmed phase. It sits between the system clock domain (clk = DCM PSCLK) and the write-clock DCM, and is controlled by a valid/ready command port from the controller or a user-input decoder.

---
 rtl/ddr_phase_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ddr_phase_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_phase_ctrl.sv
// Phase-shift and lock sequencer for the DDR write-clock DCM. Owns the DCM reset, the
// PSEN/PSINCDEC/PSDONE handshake and the feedback tap, and restores the programmed phase after relock.
module ddr_phase_ctrl #(
    parameter int PW             = 9,
    parameter int PS_ATTR        = 0,
    parameter int PS_MIN         = -255,
    parameter int PS_MAX         = 255,
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int PSDONE_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic signed [PW-1:0] cmd_arg,
    output logic                 dcm_rst,
    input  logic                 dcm_locked,
    output logic                 dcm_psen,
    output logic                 dcm_psincdec,
    input  logic                 dcm_psdone,
    output logic [1:0]           fb_sel,
    output logic signed [PW-1:0] phase,
    output logic                 locked,
    output logic [1:0]           err
);

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_IDLE      = 3'd2,
        ST_PS_ISSUE  = 3'd3,
        ST_PS_WAIT   = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int                   PW1       = PW + 1;
    localparam logic signed [PW-1:0] PHASE_RST = PW'(PS_ATTR);
    localparam logic signed [PW-1:0] PHASE_ONE = PW'(1);
    localparam logic signed [PW:0]   LIM_MIN   = PW1'(PS_MIN);
    localparam logic signed [PW:0]   LIM_MAX   = PW1'(PS_MAX);
    localparam logic [31:0]          RST_LOAD  = 32'(RST_CYCLES - 1);
    localparam logic [31:0]          LOCK_LOAD = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0]          PSD_LOAD  = 32'(PSDONE_TIMEOUT - 1);

    function automatic logic signed [PW-1:0] clamp_fn(input logic signed [PW:0] v);
        logic signed [PW:0] r;
        if (v > LIM_MAX) begin
            r = LIM_MAX;
        end else if (v < LIM_MIN) begin
            r = LIM_MIN;
        end else begin
            r = v;
        end
        return r[PW-1:0];
    endfunction

    state_t                state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  lock_meta_q, lock_sync_q;
    logic signed [PW-1:0]  phase_q, phase_d;
    logic signed [PW-1:0]  target_q, target_d;
    logic [1:0]            fb_sel_q, fb_sel_d;
    logic [1:0]            err_q, err_d;
    logic                  psincdec_q, psincdec_d;
    logic                  dcm_rst_q, dcm_psen_q, locked_q, rdy_idle_q, in_fault_q;

    logic signed [PW:0]    arg_ext_s, raw_tgt_s;
    logic signed [PW-1:0]  cmd_tgt_s, step_s;
    logic                  cmd_clamp_s;

    // Target arithmetic is done one bit wider so a relative step cannot wrap before clamping.
    assign arg_ext_s   = {cmd_arg[PW-1], cmd_arg};
    assign raw_tgt_s   = (cmd_op == 2'b00) ? ({phase_q[PW-1], phase_q} + arg_ext_s) : arg_ext_s;
    assign cmd_tgt_s   = clamp_fn(raw_tgt_s);
    assign cmd_clamp_s = ({cmd_tgt_s[PW-1], cmd_tgt_s} != raw_tgt_s);
    assign step_s      = psincdec_q ? (phase_q + PHASE_ONE) : (phase_q - PHASE_ONE);

    // Next-state and next-value logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        target_d = target_q;
        fb_sel_d = fb_sel_q;
        err_d    = err_q;
        case (state_q)
            ST_RST_HOLD: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_WAIT_LOCK;
                    phase_d = PHASE_RST;
                    cnt_d   = LOCK_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d = (phase_q != target_q) ? ST_PS_ISSUE : ST_IDLE;
                end else if (cnt_q == 32'd0) begin
                    err_d[0] = 1'b1;
                    state_d  = ST_FAULT;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_IDLE: begin
                // A command seen together with lock loss is still taken; its target is restored after relock.
                cnt_d = RST_LOAD;
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b00, 2'b01: begin
                            target_d = cmd_tgt_s;
                            err_d[1] = err_q[1] | cmd_clamp_s;
                            if (!lock_sync_q) begin
                                state_d = ST_RST_HOLD;
                            end else begin
                                state_d = (cmd_tgt_s != phase_q) ? ST_PS_ISSUE : ST_IDLE;
                            end
                        end
                        2'b10: begin
                            err_d   = 2'b00;
                            state_d = ST_RST_HOLD;
                        end
                        2'b11: begin
                            fb_sel_d = cmd_arg[1:0];
                            state_d  = ST_RST_HOLD;
                        end
                        default: state_d = lock_sync_q ? ST_IDLE : ST_RST_HOLD;
                    endcase
                end else begin
                    state_d = lock_sync_q ? ST_IDLE : ST_RST_HOLD;
                end
            end
            ST_PS_ISSUE: begin
                state_d = lock_sync_q ? ST_PS_WAIT : ST_RST_HOLD;
                cnt_d   = lock_sync_q ? PSD_LOAD : RST_LOAD;
            end
            ST_PS_WAIT: begin
                if (!lock_sync_q) begin
                    state_d = ST_RST_HOLD;
                    cnt_d   = RST_LOAD;
                end else if (dcm_psdone) begin
                    phase_d = step_s;
                    state_d = (step_s == target_q) ? ST_IDLE : ST_PS_ISSUE;
                end else if (cnt_q == 32'd0) begin
                    err_d[0] = 1'b1;
                    state_d  = ST_FAULT;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_FAULT: begin
                if (cmd_valid && (cmd_op == 2'b10)) begin
                    err_d   = 2'b00;
                    state_d = ST_RST_HOLD;
                    cnt_d   = RST_LOAD;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
                cnt_d   = RST_LOAD;
            end
        endcase
        if (state_d == ST_PS_ISSUE) begin
            psincdec_d = (target_d > phase_d);
        end else begin
            psincdec_d = psincdec_q;
        end
    end

    // State, lock synchroniser and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RST_HOLD;
            cnt_q       <= RST_LOAD;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            phase_q     <= PHASE_RST;
            target_q    <= PHASE_RST;
            fb_sel_q    <= 2'b00;
            err_q       <= 2'b00;
            psincdec_q  <= 1'b0;
            dcm_rst_q   <= 1'b1;
            dcm_psen_q  <= 1'b0;
            locked_q    <= 1'b0;
            rdy_idle_q  <= 1'b0;
            in_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= dcm_locked;
            lock_sync_q <= lock_meta_q;
            phase_q     <= phase_d;
            target_q    <= target_d;
            fb_sel_q    <= fb_sel_d;
            err_q       <= err_d;
            psincdec_q  <= psincdec_d;
            dcm_rst_q   <= (state_d == ST_RST_HOLD);
            dcm_psen_q  <= (state_d == ST_PS_ISSUE);
            locked_q    <= (state_d == ST_IDLE) || (state_d == ST_PS_ISSUE) || (state_d == ST_PS_WAIT);
            rdy_idle_q  <= (state_d == ST_IDLE);
            in_fault_q  <= (state_d == ST_FAULT);
        end
    end

    // In FAULT only the re-lock opcode is offered a ready.
    assign cmd_ready    = rdy_idle_q | (in_fault_q & (cmd_op == 2'b10));
    assign dcm_rst      = dcm_rst_q;
    assign dcm_psen     = dcm_psen_q;
    assign dcm_psincdec = psincdec_q;
    assign fb_sel       = fb_sel_q;
    assign phase        = phase_q;
    assign locked       = locked_q;
    assign err          = err_q;

endmodule

// File: tb/tb_ddr_phase_ctrl.sv
// Bench for ddr_phase_ctrl: behavioural DCM model plus a scoreboard of expected
// PSEN step directions, with one task per scenario.
module tb_ddr_phase_ctrl;

    localparam int PW = 9;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic [1:0]           cmd_op = 2'b00;
    logic signed [PW-1:0] cmd_arg = '0;
    logic                 cmd_ready, dcm_rst, dcm_psen, dcm_psincdec, locked;
    logic [1:0]           fb_sel, err;
    logic signed [PW-1:0] phase;
    logic                 dcm_locked = 1'b0;
    logic                 dcm_psdone = 1'b0;

    int total = 0, bad = 0, cyc = 0;
    bit exp_q[$];
    bit prev_psen = 1'b0;
    bit auto_done = 1'b1, force_unlock = 1'b0;
    int inj_req = 0, inj_ack = 0, pd_cnt = 0, lk_cnt = 3, lock_rise_cyc = 0;
    int m_phase = 0, m_target = 0;
    logic [1:0] m_err = 2'b00;

    always #5 clk = ~clk;

    ddr_phase_ctrl #(
        .PW(PW), .PS_ATTR(0), .PS_MIN(-255), .PS_MAX(255),
        .RST_CYCLES(16), .LOCK_TIMEOUT(65535), .PSDONE_TIMEOUT(255)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .dcm_rst(dcm_rst), .dcm_locked(dcm_locked),
        .dcm_psen(dcm_psen), .dcm_psincdec(dcm_psincdec), .dcm_psdone(dcm_psdone),
        .fb_sel(fb_sel), .phase(phase), .locked(locked), .err(err)
    );

    // DCM model: psdone 2 cycles after psen, lock 3 cycles after dcm_rst releases.
    always @(negedge clk) begin
        if (dcm_psdone) dcm_psdone = 1'b0;
        else if (pd_cnt == 1) begin dcm_psdone = 1'b1; pd_cnt = 0; end
        else if (pd_cnt > 1) pd_cnt = pd_cnt - 1;
        if (inj_ack != inj_req) begin dcm_psdone = 1'b1; inj_ack = inj_req; end
        if (dcm_psen && auto_done) pd_cnt = 2;
        if (dcm_rst || force_unlock) begin
            dcm_locked = 1'b0;
            lk_cnt = 3;
        end else if (!dcm_locked) begin
            if (lk_cnt <= 1) begin dcm_locked = 1'b1; lock_rise_cyc = cyc; end
            else lk_cnt = lk_cnt - 1;
        end
    end

    // Advance one clock; every PSEN pulse is popped from the scoreboard here.
    task automatic tick();
        bit e;
        @(posedge clk); #1; cyc++;
        if (dcm_psen === 1'b1) begin
            total++;
            if (prev_psen !== 1'b0) begin bad++; $display("FAIL psen_width: psen high on two consecutive cycles"); end
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL sb_unexpected: psen with psincdec=%0b, want no step", dcm_psincdec);
            end else begin
                e = exp_q.pop_front();
                if (dcm_psincdec !== e) begin bad++; $display("FAIL sb_dir: psincdec=%0b want %0b", dcm_psincdec, e); end
            end
        end
        prev_psen = dcm_psen;
    endtask

    task automatic push_steps(input int from, input int to);
        for (int p = from; p != to; p += (to > from) ? 1 : -1) exp_q.push_back(to > from);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic signed [PW-1:0] arg);
        bit ok;
        cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1; #1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (cmd_ready === 1'b1) ok = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL accept: op=%0d not accepted, want accepted within 400 cycles", op); end
    endtask

    task automatic wait_ready(input int max, input string name);
        int n;
        n = 0;
        while (!(cmd_ready === 1'b1 && locked === 1'b1) && n < max) begin n++; tick(); end
        total++;
        if (n >= max) begin bad++; $display("FAIL %s: ready/locked not seen, want within %0d cycles", name, max); end
    endtask

    // Model the command, push its steps, run it and check the resulting phase and err.
    task automatic move(input logic [1:0] op, input int arg, input string name);
        int raw, t;
        raw = (op == 2'b00) ? m_phase + arg : arg;
        t = (raw > 255) ? 255 : ((raw < -255) ? -255 : raw);
        if (t != raw) m_err[1] = 1'b1;
        m_target = t;
        push_steps(m_phase, t);
        send_cmd(op, PW'(arg));
        wait_ready(3000, name);
        m_phase = m_target;
        total++;
        if (phase !== PW'(m_target)) begin bad++; $display("FAIL %s_phase: got %0d want %0d", name, phase, m_target); end
        total++;
        if (err !== m_err) begin bad++; $display("FAIL %s_err: got %b want %b", name, err, m_err); end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        repeat (4) tick();
        total++;
        if ({dcm_rst, dcm_psen, dcm_psincdec, fb_sel, cmd_ready, locked, err} !== 9'b1_0_0_00_0_0_00) begin
            bad++; $display("FAIL reset_outs: got %b want 100000000",
                            {dcm_rst, dcm_psen, dcm_psincdec, fb_sel, cmd_ready, locked, err});
        end
        total++;
        if (phase !== 9'sd0) begin bad++; $display("FAIL reset_phase: got %0d want 0", phase); end
        reset = 1'b0;
        n = 0;
        while (dcm_rst === 1'b1 && n < 100) begin n++; tick(); end
        total++;
        if (n != 16) begin bad++; $display("FAIL rst_hold_len: got %0d want 16", n); end
        wait_ready(100, "first_lock");
        total++;
        if (cyc - lock_rise_cyc != 3) begin bad++; $display("FAIL lock_latency: got %0d want 3", cyc - lock_rise_cyc); end
        total++;
        if (phase !== 9'sd0 || dcm_rst !== 1'b0) begin bad++; $display("FAIL lock_state: phase=%0d rst=%b want 0 0", phase, dcm_rst); end
    endtask

    task automatic test_rel_step();
        m_target = 3;
        push_steps(m_phase, 3);
        send_cmd(2'b00, 9'sd3);
        total++;
        if (dcm_psen !== 1'b1) begin bad++; $display("FAIL psen_latency: psen=%b want 1 right after accept", dcm_psen); end
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_drop: cmd_ready=%b want 0", cmd_ready); end
        wait_ready(100, "rel_step");
        m_phase = 3;
        total++;
        if (phase !== 9'sd3) begin bad++; $display("FAIL rel_step_phase: got %0d want 3", phase); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rel_step_count: %0d steps missing want 0", exp_q.size()); end
    endtask

    task automatic test_abs_clamp();
        move(2'b01, -2, "abs_neg");
        move(2'b00, -255, "rel_clamp_min");
        move(2'b01, -256, "abs_clamp_noop");
        move(2'b01, 5, "abs_pos");
    endtask

    task automatic test_lock_loss();
        int n;
        force_unlock = 1'b1;
        n = 0;
        while (dcm_rst !== 1'b1 && n < 20) begin n++; tick(); end
        total++;
        if (dcm_rst !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL loss_detect: rst=%b locked=%b want 1 0", dcm_rst, locked); end
        push_steps(0, m_target);
        force_unlock = 1'b0;
        n = 0;
        while (dcm_rst === 1'b1 && n < 100) begin n++; tick(); end
        total++;
        if (n != 16) begin bad++; $display("FAIL loss_rst_len: got %0d want 16", n); end
        wait_ready(200, "loss_relock");
        total++;
        if (phase !== PW'(m_target) || fb_sel !== 2'd0) begin bad++; $display("FAIL loss_restore: phase=%0d fb=%0d want %0d 0", phase, fb_sel, m_target); end
    endtask

    task automatic test_fb_sel();
        push_steps(0, m_target);
        send_cmd(2'b11, 9'sd1);
        total++;
        if (fb_sel !== 2'd1 || dcm_rst !== 1'b1) begin bad++; $display("FAIL fb_sel_apply: fb=%0d rst=%b want 1 1", fb_sel, dcm_rst); end
        wait_ready(200, "fb_relock");
        total++;
        if (phase !== PW'(m_target) || fb_sel !== 2'd1) begin bad++; $display("FAIL fb_restore: phase=%0d fb=%0d want %0d 1", phase, fb_sel, m_target); end
    endtask

    task automatic test_loss_with_psdone();
        int old;
        old = m_phase;
        auto_done = 1'b0;
        m_target = old + 1;
        push_steps(old, m_target);
        send_cmd(2'b00, 9'sd1);
        force_unlock = 1'b1;
        tick(); tick();
        inj_req++;
        tick();
        total++;
        if (dcm_rst !== 1'b1 || phase !== PW'(old)) begin bad++; $display("FAIL loss_psdone: rst=%b phase=%0d want 1 %0d", dcm_rst, phase, old); end
        push_steps(0, m_target);
        m_phase = m_target;
        force_unlock = 1'b0;
        auto_done = 1'b1;
        wait_ready(200, "loss_psdone_relock");
        total++;
        if (phase !== PW'(m_target)) begin bad++; $display("FAIL loss_psdone_restore: phase=%0d want %0d", phase, m_target); end
    endtask

    task automatic test_stray_psdone();
        inj_req++;
        repeat (4) tick();
        total++;
        if (phase !== PW'(m_phase) || cmd_ready !== 1'b1) begin bad++; $display("FAIL stray_psdone: phase=%0d ready=%b want %0d 1", phase, cmd_ready, m_phase); end
    endtask

    task automatic test_timeout();
        int n;
        auto_done = 1'b0;
        m_target = m_phase - 1;
        push_steps(m_phase, m_target);
        send_cmd(2'b00, -9'sd1);
        n = 0;
        while (locked === 1'b1 && n < 400) begin n++; tick(); end
        total++;
        if (n != 256) begin bad++; $display("FAIL psdone_timeout: got %0d cycles want 256", n); end
        m_err[0] = 1'b1;
        total++;
        if (err !== m_err) begin bad++; $display("FAIL fault_err: got %b want %b", err, m_err); end
        cmd_op = 2'b00; cmd_valid = 1'b1; #1;
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fault_ready_op0: got %b want 0", cmd_ready); end
        repeat (3) tick();
        total++;
        if (locked !== 1'b0 || dcm_rst !== 1'b0) begin bad++; $display("FAIL fault_ignore: locked=%b rst=%b want 0 0", locked, dcm_rst); end
        cmd_op = 2'b10; #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL fault_ready_op2: got %b want 1", cmd_ready); end
        cmd_valid = 1'b0;
        push_steps(0, m_target);
        auto_done = 1'b1;
        send_cmd(2'b10, 9'sd0);
        m_err = 2'b00;
        total++;
        if (err !== 2'b00) begin bad++; $display("FAIL relock_err_clear: got %b want 00", err); end
        wait_ready(200, "fault_relock");
        m_phase = m_target;
        total++;
        if (phase !== PW'(m_target)) begin bad++; $display("FAIL fault_restore: phase=%0d want %0d", phase, m_target); end
    endtask

    initial begin
        test_reset();
        test_rel_step();
        test_abs_clamp();
        test_lock_loss();
        test_fb_sel();
        test_loss_with_psdone();
        test_stray_psdone();
        test_timeout();
        repeat (4) tick();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain: %0d steps outstanding want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
